// File: rtl/prm_rdcache.sv
// prm_rdcache: direct-mapped read-only line cache for one tfacc parameter bus.
// 32-bit word reads from the core, 64-bit burst refills from the memory side.
module prm_rdcache #(
  parameter int LOG2_NLINE = 4,
  parameter int LOG2_LBEAT = 3,
  parameter int AW         = 24
) (
  input  logic        aclk,
  input  logic        arst_n,
  input  logic        clr,
  input  logic [31:0] base,
  input  logic [31:0] adr,
  input  logic        re,
  output logic        rdy,
  output logic [31:0] dr,
  output logic        rreq,
  input  logic        rack,
  output logic [31:0] radr,
  output logic [7:0]  rlen,
  input  logic [63:0] rdata
);

  localparam int NLINE = 1 << LOG2_NLINE;
  localparam int NBEAT = 1 << LOG2_LBEAT;
  localparam int LO    = LOG2_LBEAT + 3;
  localparam int TL    = LO + LOG2_NLINE;
  localparam int TW    = AW - TL;
  localparam int RAW   = LOG2_NLINE + LOG2_LBEAT;

  typedef enum logic [1:0] {IDLE, MISS, FILL, RTRY} state_t;

  state_t state, state_nx;

  // Storage: tags and valids in flops, line data in a 64-bit wide RAM.
  logic [63:0]           ram [NLINE*NBEAT];
  logic [TW-1:0]         tag_mem [NLINE];
  logic [NLINE-1:0]      vld;

  // Latched miss context.
  logic [LOG2_NLINE-1:0] fill_idx;
  logic [TW-1:0]         fill_tag;
  logic [LOG2_LBEAT-1:0] cnt;
  logic                  clr_seen;

  // Address fields of the (held) request.
  logic [LOG2_NLINE-1:0] a_idx;
  logic [LOG2_LBEAT-1:0] a_beat;
  logic                  a_word;
  logic [TW-1:0]         a_tag;
  logic [31:0]           line_off;
  logic                  hit;
  logic                  lookup;
  logic                  miss_new;
  logic                  beat_acc;
  logic                  last_beat;
  logic                  unused_adr;

  assign a_word   = adr[2];
  assign a_beat   = adr[LO-1:3];
  assign a_idx    = adr[TL-1:LO];
  assign a_tag    = adr[AW-1:TL];
  assign line_off = {{(32-AW){1'b0}}, adr[AW-1:LO], {LO{1'b0}}};
  assign unused_adr = ^{adr[31:AW], adr[1:0]};

  // A clr in the lookup cycle forces a miss since it wipes every valid bit.
  assign hit       = vld[a_idx] && (tag_mem[a_idx] == a_tag) && !clr;
  assign lookup    = ((state == IDLE) && re) || (state == RTRY);
  assign miss_new  = (state == IDLE) && re && !hit;
  assign beat_acc  = ((state == MISS) || (state == FILL)) && rack;
  assign last_beat = beat_acc && (cnt == LOG2_LBEAT'(NBEAT-1));

  assign rlen = 8'(NBEAT-1);

  // State register.
  always_ff @(posedge aclk) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (re && !hit) state_nx = MISS;
      MISS,
      FILL:      if (rack) state_nx = last_beat ? RTRY : FILL;
      RTRY:      state_nx = hit ? IDLE : MISS;
      default:   state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    rdy  = (state == IDLE);
    rreq = (state == MISS) || (state == FILL);
  end

  // Control registers: valids, beat counter, clr tracking, burst address, read word.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      vld      <= '0;
      cnt      <= '0;
      clr_seen <= 1'b0;
      radr     <= '0;
      dr       <= '0;
    end else begin
      if (beat_acc) cnt <= cnt + 1'b1;

      // A new burst (fresh miss or retry miss) starts with a clean clr history.
      if (miss_new || ((state == RTRY) && !hit)) clr_seen <= 1'b0;
      else if (clr && ((state == MISS) || (state == FILL))) clr_seen <= 1'b1;

      if (clr) vld <= '0;
      else if (last_beat && !clr_seen) vld[fill_idx] <= 1'b1;

      if (miss_new) radr <= base + line_off;

      if (lookup && hit) dr <= a_word ? ram[{a_idx, a_beat}][63:32]
                                      : ram[{a_idx, a_beat}][31:0];
    end
  end

  // Data-path storage: refill writes, tag update and miss context (no reset needed).
  always_ff @(posedge aclk) begin
    if (beat_acc) ram[{fill_idx, cnt}] <= rdata;
    if (last_beat && !clr_seen && !clr) tag_mem[fill_idx] <= fill_tag;
    if (miss_new) begin
      fill_idx <= a_idx;
      fill_tag <= a_tag;
    end
  end

  // The consumer must hold the address while a request is pending.
  a_adr_stable: assert property (@(posedge aclk) disable iff (!arst_n)
                                 (!rdy && re) |-> $stable(adr));

endmodule

// File: tb/tb_prm_rdcache.sv
// Directed testbench for prm_rdcache: cold miss, hit stream, conflict,
// rack gaps, clr during fill and reset during a burst.
module tb_prm_rdcache;

  logic        aclk;
  logic        arst_n;
  logic        clr;
  logic [31:0] base;
  logic [31:0] adr;
  logic        re;
  logic        rdy;
  logic [31:0] dr;
  logic        rreq;
  logic        rack;
  logic [31:0] radr;
  logic [7:0]  rlen;
  logic [63:0] rdata;

  int n_cmp = 0;
  int n_err = 0;

  prm_rdcache #(.LOG2_NLINE(4), .LOG2_LBEAT(3), .AW(24)) dut (
    .aclk(aclk), .arst_n(arst_n), .clr(clr), .base(base), .adr(adr), .re(re),
    .rdy(rdy), .dr(dr), .rreq(rreq), .rack(rack), .radr(radr), .rlen(rlen),
    .rdata(rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Memory contents: word at byte address a is its word distance from 0x1000_0040,
  // so the line at 0x1000_0040 holds beat i = {2i+1, 2i}.
  function automatic logic [31:0] wdata(input logic [31:0] a);
    return (a - 32'h1000_0040) >> 2;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a rack pattern (bit i = rack in cycle i) starting at beat k0 of the
  // line at ra; rreq must stay high until the eighth beat has been accepted.
  task automatic burst(input logic [31:0] ra, input logic [15:0] pat,
                       input int plen, input int k0);
    int k;
    k = k0;
    for (int i = 0; i < plen; i++) begin
      rack = pat[i];
      if (pat[i]) begin
        rdata = {wdata(ra + 32'(8*k) + 32'd4), wdata(ra + 32'(8*k))};
        k++;
      end else begin
        rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      tick();
      chk("rreq_burst", {31'b0, rreq}, (k < 8) ? 32'd1 : 32'd0);
    end
    rack  = 1'b0;
    rdata = '0;
  endtask

  // Issue a request that must miss and check the burst request.
  task automatic req_miss(input logic [31:0] a, input logic [31:0] exp_radr);
    adr = a;
    re  = 1'b1;
    tick();
    chk("miss_rdy", {31'b0, rdy}, 32'd0);
    chk("miss_rreq", {31'b0, rreq}, 32'd1);
    chk("miss_radr", radr, exp_radr);
  endtask

  // After the last beat: one RTRY cycle, then rdy with the requested word.
  task automatic finish_refill(input logic [31:0] exp_dr);
    chk("rtry_rdy", {31'b0, rdy}, 32'd0);
    tick();
    chk("done_rdy", {31'b0, rdy}, 32'd1);
    chk("done_dr", dr, exp_dr);
  endtask

  task automatic req_hit(input logic [31:0] a);
    adr = a;
    re  = 1'b1;
    tick();
    chk("hit_rdy", {31'b0, rdy}, 32'd1);
    chk("hit_rreq", {31'b0, rreq}, 32'd0);
    chk("hit_dr", dr, wdata(base + a));
  endtask

  initial begin
    arst_n = 1'b0;
    clr    = 1'b0;
    base   = '0;
    adr    = '0;
    re     = 1'b0;
    rack   = 1'b0;
    rdata  = '0;
    tick();
    tick();
    chk("rst_rdy", {31'b0, rdy}, 32'd1);
    chk("rst_rreq", {31'b0, rreq}, 32'd0);
    chk("rst_radr", radr, 32'd0);
    chk("rst_dr", dr, 32'd0);
    chk("rst_rlen", {24'b0, rlen}, 32'd7);
    arst_n = 1'b1;

    // Cold miss.
    base = 32'h1000_0000;
    clr  = 1'b1;
    tick();
    clr = 1'b0;
    req_miss(32'h40, 32'h1000_0040);
    chk("cold_rlen", {24'b0, rlen}, 32'd7);
    burst(32'h1000_0040, 16'h00FF, 8, 0);
    finish_refill(32'h0000_0000);

    // Hit stream 0x44..0x7C, one word per cycle.
    for (int a = 32'h44; a <= 32'h7C; a += 4) req_hit(32'(a));

    // Conflict: 0x440 shares the index of 0x40.
    req_miss(32'h440, 32'h1000_0440);
    burst(32'h1000_0440, 16'h00FF, 8, 0);
    finish_refill(wdata(32'h1000_0440));
    req_hit(32'h454);

    // Re-access of 0x40 misses; refill with rack gaps.
    req_miss(32'h40, 32'h1000_0040);
    burst(32'h1000_0040, 16'h07D9, 11, 0);
    finish_refill(32'h0000_0000);
    req_hit(32'h58);
    req_hit(32'h6C);
    req_hit(32'h7C);

    // clr after beat 3: burst completes, retry misses, second burst refills.
    req_miss(32'h80, 32'h1000_0080);
    burst(32'h1000_0080, 16'h000F, 4, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_rreq", {31'b0, rreq}, 32'd1);
    burst(32'h1000_0080, 16'h000F, 4, 4);
    chk("clr_rtry_rdy", {31'b0, rdy}, 32'd0);
    tick();
    chk("clr_remiss_rreq", {31'b0, rreq}, 32'd1);
    chk("clr_remiss_rdy", {31'b0, rdy}, 32'd0);
    chk("clr_remiss_radr", radr, 32'h1000_0080);
    burst(32'h1000_0080, 16'h00FF, 8, 0);
    finish_refill(wdata(32'h1000_0080));
    req_hit(32'hB8);

    // Reset after beat 2 of a burst.
    req_miss(32'hC0, 32'h1000_00C0);
    burst(32'h1000_00C0, 16'h0007, 3, 0);
    arst_n = 1'b0;
    re     = 1'b0;
    tick();
    arst_n = 1'b1;
    chk("rstb_rreq", {31'b0, rreq}, 32'd0);
    chk("rstb_rdy", {31'b0, rdy}, 32'd1);
    chk("rstb_radr", radr, 32'd0);
    chk("rstb_dr", dr, 32'd0);
    req_miss(32'h40, 32'h1000_0040);
    burst(32'h1000_0040, 16'h00FF, 8, 0);
    finish_refill(32'h0000_0000);
    req_hit(32'h7C);
    re = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
